// File: rtl/rgb_pwm_pkg.sv
// Shared constants and helpers for the RGB PWM generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rgb_pwm_pkg;

   localparam int DUTY_W           = 8;
   localparam int PRESC_W          = 16;
   localparam int PRESCALE_DEFAULT = 196;

   typedef logic [DUTY_W-1:0] duty_t;

   // Last phase value; the counter wraps from here, so a period is PWM_MAX+1 ticks.
   localparam duty_t PWM_MAX = 8'd254;

   // True on the tick that ends a period and reloads the channel shadows.
   function automatic logic phase_wrap(input duty_t cnt, input logic tick);
      return tick && (cnt == PWM_MAX);
   endfunction

endpackage

// File: rtl/rgb_pwm_generator_if.sv
// Control, duty and LED-drive bundle of the RGB PWM generator.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level/pulse, no handshake.
interface rgb_pwm_generator_if;
   import rgb_pwm_pkg::*;

   logic  enable;
   duty_t R_time_in;
   duty_t G_time_in;
   duty_t B_time_in;
   logic  pwm_r;
   logic  pwm_g;
   logic  pwm_b;
   logic  period_start;

   modport master (
      output enable, R_time_in, G_time_in, B_time_in,
      input  pwm_r, pwm_g, pwm_b, period_start
   );

   modport slave (
      input  enable, R_time_in, G_time_in, B_time_in,
      output pwm_r, pwm_g, pwm_b, period_start
   );

endinterface

// File: rtl/pwm_channel.sv
// One colour channel: shadow duty register, phase comparator, polarity, output register.
// Latency: pwm follows the phase counter by one clk; a new duty lands at the next wrap.
// Backpressure: none; held inactive while enable is low.
module pwm_channel
   import rgb_pwm_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  enable,
   input  logic  load,
   input  duty_t cnt,
   input  duty_t time_in,
   output logic  pwm
);

   duty_t shadow;

   // Shadow duty: tracks the input while idle, otherwise only refreshed at the period wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
      end else if (!enable || load) begin
         shadow <= time_in;
      end
   end

   // Output drive: active while the phase is below the duty; since cnt tops out at 254, duty 255 stays on.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm <= ACTIVE_LOW;
      end else begin
         pwm <= (enable && (cnt < shadow)) ^ ACTIVE_LOW;
      end
   end

endmodule

// File: rtl/rgb_pwm_generator.sv
// RGB PWM generator: shared prescaler and 255-tick phase counter driving three duty channels.
// Latency: outputs registered one clk after the phase counter; duty changes apply at the next wrap.
// Backpressure: none; free-running while enable is high, outputs held inactive otherwise.
module rgb_pwm_generator
   import rgb_pwm_pkg::*;
#(
   parameter int PRESCALE   = PRESCALE_DEFAULT,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   rgb_pwm_generator_if.slave bus
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

   logic [PRESC_W-1:0] presc;
   duty_t              cnt;
   logic               tick;
   logic               wrap;

   assign tick = bus.enable && (presc == PRESC_LAST);
   assign wrap = phase_wrap(cnt, tick);

   // Prescaler: divides clk down to the PWM tick rate; parked at zero while idle.
   always_ff @(posedge clk) begin
      if (rst || !bus.enable) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PRESC_W'(1);
      end
   end

   // Phase counter: 0..254 per period, advancing one step per tick.
   always_ff @(posedge clk) begin
      if (rst || !bus.enable) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= (cnt == PWM_MAX) ? '0 : cnt + DUTY_W'(1);
      end
   end

   // Period marker: one-cycle pulse in the cycle after the wrap tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.period_start <= 1'b0;
      end else begin
         bus.period_start <= wrap;
      end
   end

   pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
      .clk     (clk),
      .rst     (rst),
      .enable  (bus.enable),
      .load    (wrap),
      .cnt     (cnt),
      .time_in (bus.R_time_in),
      .pwm     (bus.pwm_r)
   );

   pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
      .clk     (clk),
      .rst     (rst),
      .enable  (bus.enable),
      .load    (wrap),
      .cnt     (cnt),
      .time_in (bus.G_time_in),
      .pwm     (bus.pwm_g)
   );

   pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
      .clk     (clk),
      .rst     (rst),
      .enable  (bus.enable),
      .load    (wrap),
      .cnt     (cnt),
      .time_in (bus.B_time_in),
      .pwm     (bus.pwm_b)
   );

endmodule

// File: tb/tb_rgb_pwm_generator.sv
// Bench for rgb_pwm_generator: two instances (PRESCALE=4 active-high, PRESCALE=1 active-low)
// share one stimulus stream; a cycle-position model predicts every output each clk,
// and directed scenarios pin duty counts and period spacing with literal values.
module tb_rgb_pwm_generator;
   import rgb_pwm_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   logic  enable;
   duty_t r_in, g_in, b_in;

   always #5 clk = ~clk;

   rgb_pwm_generator_if if4 ();
   rgb_pwm_generator_if if1 ();

   assign if4.enable    = enable;
   assign if4.R_time_in = r_in;
   assign if4.G_time_in = g_in;
   assign if4.B_time_in = b_in;
   assign if1.enable    = enable;
   assign if1.R_time_in = r_in;
   assign if1.G_time_in = g_in;
   assign if1.B_time_in = b_in;

   rgb_pwm_generator #(.PRESCALE(4), .ACTIVE_LOW(1'b0)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (if4.slave)
   );

   rgb_pwm_generator #(.PRESCALE(1), .ACTIVE_LOW(1'b1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   int checks = 0;
   int errors = 0;

   function automatic int presc_of(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   function automatic bit al_of(input int d);
      return (d == 0) ? 1'b0 : 1'b1;
   endfunction

   // {pwm_r, pwm_g, pwm_b, period_start}
   function automatic logic [3:0] obs_of(input int d);
      if (d == 0) return {if4.pwm_r, if4.pwm_g, if4.pwm_b, if4.period_start};
      return {if1.pwm_r, if1.pwm_g, if1.pwm_b, if1.period_start};
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at t=%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // k = clk cycles elapsed since counting (re)started; tick number = k/P,
   // phase = tick number mod 255; the period ends on its last clk cycle.
   int         k      [2];
   int         duty   [2][3];
   logic [3:0] exp_o  [2];
   bit         mvalid = 1'b0;

   always @(posedge clk) begin
      int p;
      int ph;
      bit a;
      bit last;
      for (int d = 0; d < 2; d++) begin
         p = presc_of(d);
         a = al_of(d);
         if (rst) begin
            exp_o[d] = {a, a, a, 1'b0};
            duty[d]  = '{0, 0, 0};
            k[d]     = 0;
         end else if (!enable) begin
            exp_o[d]   = {a, a, a, 1'b0};
            duty[d][0] = r_in;
            duty[d][1] = g_in;
            duty[d][2] = b_in;
            k[d]       = 0;
         end else begin
            ph   = (k[d] / p) % 255;
            last = ((k[d] % (255 * p)) == (255 * p - 1));
            exp_o[d] = {(ph < duty[d][0]) ^ a, (ph < duty[d][1]) ^ a,
                        (ph < duty[d][2]) ^ a, last};
            if (last) begin
               duty[d][0] = r_in;
               duty[d][1] = g_in;
               duty[d][2] = b_in;
            end
            k[d] = (k[d] + 1) % (255 * p);
         end
      end
      if (rst) mvalid = 1'b1;
   end

   // ---------------- per-cycle compare + period spacing ----------------
   int cyc = 0;
   int last_ps  [2] = '{0, 0};
   bit have_ps  [2] = '{1'b0, 1'b0};
   bit disturbed[2] = '{1'b1, 1'b1};

   always @(posedge clk) begin
      logic [3:0] o;
      string nm [4];
      nm = '{"pwm_r", "pwm_g", "pwm_b", "period_start"};
      #1;
      cyc++;
      if (mvalid) begin
         for (int d = 0; d < 2; d++) begin
            o = obs_of(d);
            for (int i = 0; i < 4; i++) begin
               checks++;
               if (o[3-i] !== exp_o[d][3-i]) begin
                  errors++;
                  $display("FAIL model dut%0d %s got %b expected %b cycle %0d",
                           d, nm[i], o[3-i], exp_o[d][3-i], cyc);
               end
            end
            if (o[0] === 1'b1) begin
               if (have_ps[d] && !disturbed[d])
                  chk($sformatf("ps_spacing_dut%0d", d), cyc - last_ps[d], 255 * presc_of(d));
               last_ps[d]   = cyc;
               have_ps[d]   = 1'b1;
               disturbed[d] = 1'b0;
            end
            if (rst || !enable) disturbed[d] = 1'b1;
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_ps(input int d, input int bound);
      bit found;
      found = 1'b0;
      for (int n = 0; n < bound && !found; n++) begin
         @(negedge clk);
         if (obs_of(d)[0] === 1'b1) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL wait_ps dut%0d no period_start within %0d cycles", d, bound);
      end
   endtask

   // Counts active cycles per colour from the cycle after one period_start up to
   // and including the next one; optionally changes R part-way through.
   task automatic count_window(input int d, input int chg_at, input int new_r,
                               output int ar, output int ag, output int ab, output int len);
      logic [3:0] o;
      bit a;
      a = al_of(d);
      ar = 0; ag = 0; ab = 0; len = 0;
      for (int n = 1; n <= 3000; n++) begin
         @(negedge clk);
         o = obs_of(d);
         if (o[3] ^ a) ar++;
         if (o[2] ^ a) ag++;
         if (o[1] ^ a) ab++;
         if (n == chg_at) r_in = duty_t'(new_r);
         if (o[0] === 1'b1) begin
            len = n;
            break;
         end
      end
   endtask

   function automatic duty_t pick_duty();
      case ($urandom_range(7, 0))
         0:       return 8'd0;
         1:       return 8'd255;
         2:       return 8'd254;
         3:       return 8'd1;
         default: return duty_t'($urandom_range(255, 0));
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int ar, ag, ab, len;
      int off_cnt, rst_cnt;
      rst    = 1'b1;
      enable = 1'b1;
      r_in   = 8'd0;
      g_in   = 8'd128;
      b_in   = 8'd255;

      // Reset with enable high: reset wins, outputs at inactive level.
      repeat (3) @(negedge clk);
      chk("reset_dut4_outputs", int'(obs_of(0)), 4'b0000);
      chk("reset_dut1_outputs", int'(obs_of(1)), 4'b1110);
      rst = 1'b0;

      // First period after reset runs with duty 0: active-low outputs stay 1.
      repeat (100) @(negedge clk);
      chk("first_period_dut1_rgb", int'(obs_of(1)[3:1]), 3'b111);
      wait_ps(1, 300);
      for (int w = 0; w < 2; w++) begin
         count_window(1, 0, 0, ar, ag, ab, len);
         chk("p1_r_active", ar, 0);
         chk("p1_g_active", ag, 128);
         chk("p1_b_active", ab, 255);
         chk("p1_period_len", len, 255);
      end

      // Duty change mid-period only applies to the following period.
      r_in = 8'd64;
      wait_ps(0, 1100);
      count_window(0, 100, 200, ar, ag, ab, len);
      chk("p4_r_old_duty", ar, 256);
      chk("p4_len_a", len, 1020);
      count_window(0, 0, 0, ar, ag, ab, len);
      chk("p4_r_new_duty", ar, 800);
      chk("p4_g_duty", ag, 512);
      chk("p4_len_b", len, 1020);

      // Disable at cnt=100, then re-enable with a fresh green duty.
      wait_ps(0, 1100);
      repeat (400) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("disable_dut4_outputs", int'(obs_of(0)), 4'b0000);
      g_in = 8'd10;
      repeat (4) @(negedge clk);
      enable = 1'b1;
      count_window(0, 0, 0, ar, ag, ab, len);
      chk("reenable_g_active", ag, 40);
      chk("reenable_r_active", ar, 800);
      chk("reenable_len", len, 1020);

      // Reset at cnt=200 with R=255: a full duty-0 period, then fully on.
      wait_ps(0, 1100);
      repeat (800) @(negedge clk);
      r_in = 8'd255;
      rst  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      count_window(0, 0, 0, ar, ag, ab, len);
      chk("rst_mid_r_first", ar, 0);
      chk("rst_mid_len_first", len, 1020);
      count_window(0, 0, 0, ar, ag, ab, len);
      chk("rst_mid_r_next", ar, 1020);
      chk("rst_mid_len_next", len, 1020);

      // Randomized traffic checked by the model.
      off_cnt = 0;
      rst_cnt = 0;
      for (int n = 0; n < 6000; n++) begin
         @(negedge clk);
         if ($urandom_range(39, 0) == 0) begin
            case ($urandom_range(2, 0))
               0:       r_in = pick_duty();
               1:       g_in = pick_duty();
               default: b_in = pick_duty();
            endcase
         end
         if (rst_cnt > 0) begin
            rst_cnt--;
            rst = (rst_cnt > 0);
         end else if ($urandom_range(1499, 0) == 0) begin
            rst_cnt = $urandom_range(3, 1);
            rst = 1'b1;
         end
         if (off_cnt > 0) begin
            off_cnt--;
            enable = (off_cnt == 0);
         end else if ($urandom_range(399, 0) == 0) begin
            off_cnt = $urandom_range(30, 1);
            enable = 1'b0;
         end
      end
      rst    = 1'b0;
      enable = 1'b1;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rgb_pwm_generator.md
RGB_PWM_GENERATOR -- requirements
Module: rgb_pwm_generator

Interface
REQ-001 Parameter PRESCALE, default 196: clk cycles per PWM tick; legal range 1..65535.
REQ-002 Parameter ACTIVE_LOW, default 0: 1 inverts all three pwm outputs, for common-anode LEDs.
REQ-003 clk  input  1  system clock; only clock in the block.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  1 = PWM running; 0 = outputs held inactive.
REQ-006 R_time_in  input  8  red duty, 0..255, driven by the colour decoder stage.
REQ-007 G_time_in  input  8  green duty, 0..255.
REQ-008 B_time_in  input  8  blue duty, 0..255.
REQ-009 pwm_r  output  1  red LED drive, registered.
REQ-010 pwm_g  output  1  green LED drive, registered.
REQ-011 pwm_b  output  1  blue LED drive, registered.
REQ-012 period_start  output  1  one-cycle pulse, registered, marking PWM counter wrap.

Function
REQ-013 16-bit prescaler counts 0..PRESCALE-1 while enable=1; tick = (presc == PRESCALE-1); presc wraps to 0 on tick.
REQ-014 8-bit phase counter cnt counts 0..254 and advances only on tick; a tick at 254 wraps it to 0, giving a 255-tick period.
REQ-015 Each channel has an 8-bit shadow duty register, loaded from its *_time_in input on a tick while cnt==254; input changes elsewhere in the period are ignored.
REQ-016 Channel active level = (cnt < shadow), evaluated from the current cnt register value; pwm_x is registered one clk later, XORed with ACTIVE_LOW.
REQ-017 Duty 0 gives the inactive level for the whole period; duty 255 gives the active level for the whole period, because cnt never reaches 255.
REQ-018 Duty d gives exactly d active ticks per period, i.e. d*PRESCALE clk cycles.
REQ-019 period_start = 1 for exactly the one clk cycle after the tick at which cnt wraps 254->0.
REQ-020 enable=0: presc and cnt are forced to 0, pwm_x are inactive on the next edge, period_start=0, and shadows load from the inputs every cycle.
REQ-021 enable 0->1: counting resumes from presc=0, cnt=0 using the shadow values captured on the last disabled cycle.
REQ-022 PRESCALE=1: a tick occurs every cycle; a period is 255 clk cycles.
REQ-023 rst and enable together: rst has priority.

Reset
REQ-024 On rst: presc=0, cnt=0, all shadows=0, pwm_r/g/b = inactive level (ACTIVE_LOW value), period_start=0.
REQ-025 rst asserted mid-period takes effect at the next clk edge. After rst is released, the first period runs with duty 0 until the first wrap-load.

Structure
REQ-026 Shared package rgb_pwm_pkg holds DUTY_W=8, PWM_MAX=8'd254, and the default PRESCALE constant.
REQ-027 Per-channel logic (shadow register, comparator, output register, polarity) is sub-module pwm_channel, instantiated three times. Prescaler and phase counter are shared in the top level.

Verification
REQ-028 PRESCALE=1, enable=1, R/G/B = 0/128/255 held -> per 255-cycle period after first wrap: pwm_r high 0 cycles, pwm_g 128, pwm_b 255.
REQ-029 PRESCALE=4, R changes 64->200 mid-period -> current period keeps 64 ticks (256 cycles); next period has 200 ticks (800 cycles); period_start pulses every 1020 cycles.
REQ-030 ACTIVE_LOW=1, duty 0 -> pwm outputs constant 1; after rst, outputs=1 on the cycle following the reset edge.
REQ-031 enable dropped at cnt=100 -> next edge: pwm inactive, cnt=0. Re-enable with G=10 -> pwm_g active for first 10 ticks of the first period.
REQ-032 rst pulsed at cnt=200 with R=255 -> pwm_r inactive until the first wrap-load (255 ticks), then constant active.
REQ-033 Bench checks period_start spacing = 255*PRESCALE cycles, with no pulse while enable=0 or rst=1.
